// File: rtl/band_modulator_if.sv
// Sample-stream bundle between the envelope follower side and a band_modulator.
interface band_modulator_if #(
   parameter int unsigned WIDTH = 24
);
   logic                    valid_in;
   logic signed [WIDTH-1:0] carrier_in;
   logic signed [WIDTH-1:0] envelope_in;
   logic signed [WIDTH-1:0] sample_out;
   logic                    valid_out;
   logic                    gate_open_out;

   modport master (
      output valid_in, carrier_in, envelope_in,
      input  sample_out, valid_out, gate_open_out
   );

   modport slave (
      input  valid_in, carrier_in, envelope_in,
      output sample_out, valid_out, gate_open_out
   );
endinterface

// File: rtl/band_modulator.sv
// Per-band vocoder VCA: carrier * clamped envelope, scaled and saturated, 3-stage pipeline.
// Define BAND_MODULATOR_GATE_EN to build in the hold-timed noise gate.
module band_modulator #(
   parameter int unsigned WIDTH        = 24,
   parameter int unsigned GAIN_LOG2    = 4,
   parameter int unsigned GATE_THRESH  = 256,
   parameter int unsigned HOLD_SAMPLES = 480
) (
   input logic           clk_in,
   input logic           rst_in,
   band_modulator_if.slave bus
);

   generate
      if (GAIN_LOG2 > WIDTH - 1) begin : g_bad_gain
         $error("band_modulator: GAIN_LOG2 must be in 0..WIDTH-1");
      end
   endgenerate

   localparam int unsigned SHIFT = WIDTH - 1 - GAIN_LOG2;
   localparam logic signed [2*WIDTH-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [2*WIDTH-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic                      s1_valid_q, s2_valid_q, valid_q;
   logic signed [WIDTH-1:0]   s1_carrier_q, s1_env_q;
   logic signed [2*WIDTH-1:0] s2_prod_q;
   logic                      s2_pass_q;
   logic signed [WIDTH-1:0]   sample_q;
   logic signed [WIDTH-1:0]   env_c;
   logic signed [2*WIDTH-1:0] scaled;
   logic signed [WIDTH-1:0]   sat;
   logic                      s1_pass;

   // Envelope follower can undershoot below zero; treat that as silence.
   assign env_c = bus.envelope_in[WIDTH-1] ? '0 : bus.envelope_in;

   always_comb begin
      scaled = s2_prod_q >>> SHIFT;
      if (scaled > SAT_MAX) begin
         sat = SAT_MAX[WIDTH-1:0];
      end else if (scaled < SAT_MIN) begin
         sat = SAT_MIN[WIDTH-1:0];
      end else begin
         sat = scaled[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_valid_q   <= 1'b0;
         s2_valid_q   <= 1'b0;
         valid_q      <= 1'b0;
         s1_carrier_q <= '0;
         s1_env_q     <= '0;
         s2_prod_q    <= '0;
         s2_pass_q    <= 1'b0;
         sample_q     <= '0;
      end else begin
         s1_valid_q <= bus.valid_in;
         s2_valid_q <= s1_valid_q;
         valid_q    <= s2_valid_q;
         if (bus.valid_in) begin
            s1_carrier_q <= bus.carrier_in;
            s1_env_q     <= env_c;
         end
         if (s1_valid_q) begin
            s2_prod_q <= (2*WIDTH)'(s1_carrier_q) * (2*WIDTH)'(s1_env_q);
            s2_pass_q <= s1_pass;
         end
         if (s2_valid_q) begin
            sample_q <= s2_pass_q ? sat : '0;
         end
      end
   end

   assign bus.sample_out = sample_q;
   assign bus.valid_out  = valid_q;

`ifdef BAND_MODULATOR_GATE_EN
   localparam int unsigned HOLD_LIM = (HOLD_SAMPLES == 0) ? 1 : HOLD_SAMPLES;
   localparam int unsigned CNT_W    = $clog2(HOLD_LIM + 1);

   typedef enum logic [1:0] {StOpen, StHold, StClosed} gate_state_e;

   gate_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             gate_open_q;
   logic             above;
   logic             hold_done;

   assign above     = $unsigned(s1_env_q) >= WIDTH'(GATE_THRESH);
   assign hold_done = (32'(cnt_q) + 32'd1) >= HOLD_LIM;

   // Pass flag is the post-update gate state, so a reopening sample is heard.
   always_comb begin
      s1_pass = 1'b1;
      case (state_q)
         StOpen:   s1_pass = above || (HOLD_LIM > 1);
         StHold:   s1_pass = above || !hold_done;
         StClosed: s1_pass = above;
         default:  s1_pass = 1'b1;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= StOpen;
         cnt_q       <= '0;
         gate_open_q <= 1'b1;
      end else if (s1_valid_q) begin
         gate_open_q <= s1_pass;
         case (state_q)
            StOpen: begin
               if (!above) begin
                  cnt_q   <= CNT_W'(1);
                  state_q <= (HOLD_LIM > 1) ? StHold : StClosed;
               end
            end
            StHold: begin
               if (above) begin
                  state_q <= StOpen;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (hold_done) state_q <= StClosed;
               end
            end
            StClosed: begin
               if (above) begin
                  state_q <= StOpen;
                  cnt_q   <= '0;
               end
            end
            default: state_q <= StOpen;
         endcase
      end
   end

   assign bus.gate_open_out = gate_open_q;
`else
   assign s1_pass           = 1'b1;
   assign bus.gate_open_out = 1'b1;
`endif

endmodule

// File: tb/tb_band_modulator.sv
// Directed bench for band_modulator: two instances (GAIN_LOG2 = 0 and 4) share one stimulus.
module tb_band_modulator;
   localparam int unsigned W = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   band_modulator_if #(.WIDTH(W)) bus0 ();
   band_modulator_if #(.WIDTH(W)) bus4 ();

   band_modulator #(.WIDTH(W), .GAIN_LOG2(0), .GATE_THRESH(256), .HOLD_SAMPLES(4)) u_g0 (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus0.slave)
   );

   band_modulator #(.WIDTH(W), .GAIN_LOG2(4), .GATE_THRESH(256), .HOLD_SAMPLES(4)) u_g4 (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus4.slave)
   );

   typedef struct {
      logic [W-1:0] carrier;
      logic [W-1:0] env;
      logic [W-1:0] exp0;
      logic [W-1:0] exp4;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] c, input logic [W-1:0] e);
      bus0.valid_in = v; bus0.carrier_in = c; bus0.envelope_in = e;
      bus4.valid_in = v; bus4.carrier_in = c; bus4.envelope_in = e;
   endtask

   // One strobe, then wait (bounded) for the result; checks latency, values and 1-cycle valid.
   task automatic strobe(input string name, input logic [W-1:0] c, input logic [W-1:0] e,
                         input logic [W-1:0] exp0, input logic [W-1:0] exp4, input bit chk);
      int lat;
      @(posedge clk); #1;
      drive(1'b1, c, e);
      @(posedge clk); #1;
      drive(1'b0, '0, '0);
      lat = 1;
      while (!bus0.valid_out && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, " latency"}, lat, 3);
      check({name, " valid4"}, {31'd0, bus4.valid_out}, 1);
      if (chk) begin
         check({name, " g0"}, {8'd0, bus0.sample_out}, {8'd0, exp0});
         check({name, " g4"}, {8'd0, bus4.sample_out}, {8'd0, exp4});
      end
      @(posedge clk); #1;
      check({name, " valid drop"}, {31'd0, bus0.valid_out}, 0);
      if (chk) check({name, " hold"}, {8'd0, bus0.sample_out}, {8'd0, exp0});
   endtask

   initial begin
      vecs[0] = '{24'h400000, 24'h400000, 24'h200000, 24'h7FFFFF};
      vecs[1] = '{24'hC00000, 24'h400000, 24'hE00000, 24'h800000};
      vecs[2] = '{24'h400000, 24'hFFFF00, 24'h000000, 24'h000000};
      vecs[3] = '{24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'hFFFFFF};
      vecs[4] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFE, 24'h7FFFFF};
      vecs[5] = '{24'h800000, 24'h7FFFFF, 24'h800001, 24'h800000};
      vecs[6] = '{24'h0003E8, 24'h100000, 24'h00007D, 24'h0007D0};
      vecs[7] = '{24'hFFFFFD, 24'h400000, 24'hFFFFFE, 24'hFFFFE8};

      drive(1'b0, '0, '0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset sample", {8'd0, bus0.sample_out}, 0);
      check("reset valid", {31'd0, bus0.valid_out}, 0);
      check("reset gate", {31'd0, bus0.gate_open_out}, 1);

      for (int i = 0; i < 8; i++) begin
         strobe($sformatf("vec%0d", i), vecs[i].carrier, vecs[i].env, vecs[i].exp0,
                vecs[i].exp4, 1'b1);
      end

      // Back-to-back ramp: carrier k with full-scale env gives k-1 (g0) and 16k-1 (g4).
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (c >= 3 && c <= 10) begin
            check($sformatf("ramp valid c%0d", c), {31'd0, bus0.valid_out}, 1);
            check($sformatf("ramp g0 c%0d", c), {8'd0, bus0.sample_out}, c - 3);
            check($sformatf("ramp g4 c%0d", c), {8'd0, bus4.sample_out}, 16 * (c - 2) - 1);
         end
         if (c == 11) check("ramp end valid", {31'd0, bus0.valid_out}, 0);
         if (c < 8) drive(1'b1, W'(c + 1), 24'h7FFFFF);
         else drive(1'b0, '0, '0);
      end

      // Reset with two samples in flight: both must vanish.
      @(posedge clk); #1;
      drive(1'b1, 24'h400000, 24'h400000);
      @(posedge clk); #1;
      drive(1'b1, 24'h200000, 24'h400000);
      @(posedge clk); #1;
      drive(1'b0, '0, '0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst sample", {8'd0, bus0.sample_out}, 0);
      check("rst gate", {31'd0, bus0.gate_open_out}, 1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst no valid %0d", k), {31'd0, bus0.valid_out}, 0);
         @(posedge clk); #1;
      end

`ifdef BAND_MODULATOR_GATE_EN
      // env=100 is below 256: gate closes once 4 consecutive samples are seen.
      for (int k = 1; k <= 3; k++) begin
         strobe($sformatf("gate low%0d", k), 24'h400000, 24'd100, 24'h000032, 24'h000320, 1'b1);
         check($sformatf("gate open%0d", k), {31'd0, bus0.gate_open_out}, 1);
      end
      strobe("gate low4", 24'h400000, 24'd100, 24'h0, 24'h0, 1'b0);
      check("gate closed", {31'd0, bus0.gate_open_out}, 0);
      strobe("gate muted", 24'h400000, 24'd100, 24'h000000, 24'h000000, 1'b1);
      check("gate still closed", {31'd0, bus0.gate_open_out}, 0);
      strobe("gate reopen", 24'h400000, 24'd256, 24'h000080, 24'h000800, 1'b1);
      check("gate reopened", {31'd0, bus0.gate_open_out}, 1);
`else
      strobe("ungated low", 24'h400000, 24'd100, 24'h000032, 24'h000320, 1'b1);
      check("ungated gate", {31'd0, bus0.gate_open_out}, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
